// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked arbiter feeding one byte stream, with stall timeout
module uart_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int TIMEOUT = 4800,
  parameter int CNT_W   = 13
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_evt
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d, rr_q, rr_d, sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tevt_q, tevt_d, found;
  logic [3:0]       valid4, last4, ready4;
  logic [31:0]      data4;
  int               j;
  // widen to four sources so a 2-bit grant index is always in range
  assign valid4 = 4'(src_valid);
  assign last4  = 4'(src_last);
  assign data4  = 32'(src_data);
  assign ready4 = 4'(uart_in_ready) << grant_q;
  assign busy        = state_q == LOCKED;
  assign grant_id    = grant_q;
  assign timeout_evt = tevt_q;
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = (int'(rr_q) + k) % NUM_SRC;
      if (!found && valid4[2'(j)]) begin
        sel   = 2'(j);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    tevt_d        = 1'b0;
    uart_in_data  = busy ? data4[8*grant_q +: 8] : 8'h00;
    uart_in_valid = busy && valid4[grant_q];
    src_ready     = busy ? ready4[NUM_SRC-1:0] : '0;
    if (!busy) begin
      if (found) begin
        grant_d = sel;
        state_d = LOCKED;
        cnt_d   = '0;
      end
    end else if (valid4[grant_q]) begin
      cnt_d = '0;
      if (uart_in_ready && last4[grant_q]) begin
        state_d = IDLE;
        rr_d    = grant_q;
      end
    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
      state_d = IDLE;
      rr_d    = grant_q;
      tevt_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      rr_q    <= 2'(NUM_SRC - 1);
      cnt_q   <= '0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tevt_q  <= tevt_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant, passthrough, rotation, backpressure, timeout and reset
module tb_uart_tx_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic [23:0] src_data = '0;
  logic [2:0]  src_valid = '0, src_last = '0, src_ready;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid, uart_in_ready = 1'b1;
  logic [1:0]  grant_id;
  logic        busy, timeout_evt;
  int          errors = 0, checks = 0;

  uart_tx_arbiter #(.NUM_SRC(3), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk_48mhz(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .uart_in_data(uart_in_data),
    .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready), .grant_id(grant_id),
    .busy(busy), .timeout_evt(timeout_evt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic v, input logic [7:0] d, input logic l);
    src_valid[i]      = v;
    src_data[8*i +: 8] = d;
    src_last[i]       = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic out(input string tag, input logic [1:0] g, input logic [7:0] d, input logic [2:0] r);
    #1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_gnt"}, grant_id, g);
    chk({tag, "_valid"}, uart_in_valid, 1);
    chk({tag, "_data"}, uart_in_data, d);
    chk({tag, "_rdy"}, src_ready, r);
  endtask

  task automatic idle(input string tag, input logic [1:0] g);
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, uart_in_valid, 0);
    chk({tag, "_rdy"}, src_ready, 0);
    chk({tag, "_gnt"}, grant_id, g);
  endtask

  initial begin
    do_reset();
    idle("rst", 0);
    chk("rst_tevt", timeout_evt, 0);
    // single source "Hi\n"
    src(0, 1, 8'h48, 0);
    idle("arb", 0);
    chk("arb_data", uart_in_data, 0);
    tick(); out("hi0", 0, 8'h48, 3'b001);
    tick(); src(0, 1, 8'h69, 0); out("hi1", 0, 8'h69, 3'b001);
    tick(); src(0, 1, 8'h0A, 1); out("hi2", 0, 8'h0A, 3'b001);
    tick(); src(0, 0, 8'h00, 0); idle("hi_end", 0);
    // contention from reset: src0 first, then src1
    do_reset();
    src(0, 1, 8'hA0, 0); src(1, 1, 8'hB0, 0);
    tick(); out("c0", 0, 8'hA0, 3'b001);
    tick(); src(0, 1, 8'hA1, 1); out("c1", 0, 8'hA1, 3'b001);
    tick(); src(0, 0, 8'h00, 0); idle("c_gap", 0);
    tick(); out("c2", 1, 8'hB0, 3'b010);
    tick(); src(1, 1, 8'hB1, 1); out("c3", 1, 8'hB1, 3'b010);
    tick(); src(1, 0, 8'h00, 0); idle("c_end", 1);
    // rotation: rr=1 -> src0 wins; then rr=0 -> src1 wins over a still-requesting src0
    src(0, 1, 8'hA0, 1); src(1, 1, 8'hB0, 1);
    tick(); out("r0", 0, 8'hA0, 3'b001);
    tick(); idle("r_gap0", 0);
    tick(); out("r1", 1, 8'hB0, 3'b010);
    tick(); src(1, 0, 8'h00, 0); idle("r_gap1", 1);
    tick(); out("r2", 0, 8'hA0, 3'b001);
    tick(); src(0, 0, 8'h00, 0); idle("r_end", 0);
    // backpressure well beyond TIMEOUT never times out
    uart_in_ready = 1'b0;
    src(2, 1, 8'hC3, 1);
    tick(); out("bp", 2, 8'hC3, 3'b000);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("bp_tevt", timeout_evt, 0);
      chk("bp_rdy", src_ready, 0);
      chk("bp_busy", busy, 1);
    end
    uart_in_ready = 1'b1;
    out("bp_go", 2, 8'hC3, 3'b100);
    tick(); src(2, 0, 8'h00, 0); idle("bp_end", 2);
    chk("bp_tevt_end", timeout_evt, 0);
    // timeout exactly 16 cycles after the owner drops valid
    do_reset();
    src(0, 1, 8'h31, 0); src(1, 1, 8'h55, 1);
    tick(); out("to0", 0, 8'h31, 3'b001);
    tick(); src(0, 0, 8'h00, 0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_wait_tevt", timeout_evt, 0);
      chk("to_wait_busy", busy, 1);
      chk("to_wait_valid", uart_in_valid, 0);
    end
    tick();
    chk("to_tevt", timeout_evt, 1);
    idle("to_rel", 0);
    tick(); chk("to_tevt_pulse", timeout_evt, 0); out("to1", 1, 8'h55, 3'b010);
    tick(); src(1, 0, 8'h00, 0); idle("to_end", 1);
    // reset mid-message abandons src2 and restores grant_id=0
    src(2, 1, 8'h10, 0);
    tick(); out("m0", 2, 8'h10, 3'b100);
    tick(); src(2, 1, 8'h11, 0); out("m1", 2, 8'h11, 3'b100);
    tick(); src(2, 1, 8'h12, 0);
    reset = 1'b1;
    tick(); reset = 1'b0; src(2, 0, 8'h00, 0);
    idle("m_rst", 0);
    src(1, 1, 8'h77, 1);
    tick(); out("m_src1", 1, 8'h77, 3'b010);
    tick(); src(1, 0, 8'h00, 0); idle("m_end", 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
